// File: rtl/mac_mdc_engine.sv
// Streaming MAC kernel: element-wise multiply, dot product, or dot product with a shifted bias.
// Define MAC_MDC_SAT_EN for saturating results and a sticky flag_sat output.
//
// state  | meaning
// IDLE   | no job; waits for work and latches the configuration
// STREAM | MUL job: 1-stage product pipe driving d directly
// LOAD_C | DOT_BIAS job: waits for the bias word and preloads acc
// ACCUM  | takes cfg_len a/b pairs and accumulates their products
// FLUSH  | last product drains into acc
// OUT    | presents acc on d until the handshake
module mac_mdc_engine #(
  parameter int DATA_W  = 32,
  parameter int CNT_LEN = 4096
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        a_TVALID,
  output logic                        a_TREADY,
  input  logic [DATA_W-1:0]           a_TDATA,
  input  logic                        b_TVALID,
  output logic                        b_TREADY,
  input  logic [DATA_W-1:0]           b_TDATA,
  input  logic                        c_TVALID,
  output logic                        c_TREADY,
  input  logic [DATA_W-1:0]           c_TDATA,
  output logic                        d_TVALID,
  input  logic                        d_TREADY,
  output logic [DATA_W-1:0]           d_TDATA,
  input  logic [1:0]                  reg_mode,
  input  logic [$clog2(DATA_W)-1:0]   reg_shift,
  input  logic [$clog2(CNT_LEN)-1:0]  reg_len,
  output logic                        flag_idle
`ifdef MAC_MDC_SAT_EN
  ,
  output logic                        flag_sat
`endif
);
  localparam int LEN_W  = $clog2(CNT_LEN);
  localparam int SH_W   = $clog2(DATA_W);
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = PROD_W + LEN_W;
  localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_STREAM, S_LOAD_C, S_ACCUM, S_FLUSH, S_OUT
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [SH_W-1:0]          r_cfg_shift;
  logic [LEN_W:0]           r_cfg_len, r_cnt, w_len_eff;
  logic signed [ACC_W-1:0]  r_acc, w_mult_ext, w_c_ext, w_sel;
  logic signed [PROD_W-1:0] r_mult, w_prod;
  logic                     r_mult_vld;
  logic                     w_work, w_ab_acc, w_pair_hs, w_d_hs, w_c_hs;
  logic                     w_cnt_ok, w_cnt_last;
  logic [DATA_W-1:0]        w_res;

  assign w_len_eff  = (reg_len == '0) ? CNT_ONE : {1'b0, reg_len};
  assign w_work     = (reg_mode == 2'd2) ? c_TVALID : (a_TVALID & b_TVALID);
  assign w_prod     = $signed({{DATA_W{a_TDATA[DATA_W-1]}}, a_TDATA}) *
                      $signed({{DATA_W{b_TDATA[DATA_W-1]}}, b_TDATA});
  assign w_mult_ext = {{LEN_W{r_mult[PROD_W-1]}}, r_mult};
  assign w_c_ext    = {{(ACC_W-DATA_W){c_TDATA[DATA_W-1]}}, c_TDATA};
  assign w_cnt_ok   = (r_cnt < r_cfg_len);
  assign w_cnt_last = ((r_cnt + CNT_ONE) == r_cfg_len);

  assign d_TVALID  = (r_state == S_OUT) || ((r_state == S_STREAM) && r_mult_vld);
  assign w_d_hs    = d_TVALID & d_TREADY;
  assign w_pair_hs = a_TVALID & b_TVALID & w_ab_acc;
  assign a_TREADY  = w_pair_hs;
  assign b_TREADY  = w_pair_hs;
  assign w_c_hs    = c_TVALID & c_TREADY;
  assign flag_idle = (r_state == S_IDLE) && !r_mult_vld;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ab_acc    = 1'b0;
    c_TREADY    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_work) begin
          case (reg_mode)
            2'd1:    w_state_nxt = S_ACCUM;
            2'd2:    w_state_nxt = S_LOAD_C;
            default: w_state_nxt = S_STREAM;
          endcase
        end
      end
      S_STREAM: begin
        // the pipe slot frees either when empty or when its result leaves this cycle
        w_ab_acc = !r_mult_vld || w_d_hs;
        if (!r_mult_vld && !(a_TVALID && b_TVALID)) w_state_nxt = S_IDLE;
      end
      S_LOAD_C: begin
        c_TREADY = 1'b1;
        if (c_TVALID) w_state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        w_ab_acc = w_cnt_ok;
        if (a_TVALID && b_TVALID && w_cnt_ok && w_cnt_last) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: w_state_nxt = S_OUT;
      S_OUT:   if (w_d_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_cfg_shift <= '0;
      r_cfg_len   <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mult      <= '0;
      r_mult_vld  <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_work) begin
        r_cfg_shift <= reg_shift;
        r_cfg_len   <= w_len_eff;
      end
      if (w_pair_hs) begin
        r_mult     <= w_prod;
        r_mult_vld <= 1'b1;
      end else if ((r_state != S_STREAM) || w_d_hs) begin
        r_mult_vld <= 1'b0;
      end
      if ((r_state == S_IDLE) && w_work && (reg_mode == 2'd1))
        r_acc <= '0;
      else if (w_c_hs)
        r_acc <= w_c_ext <<< r_cfg_shift;
      else if (r_mult_vld && ((r_state == S_ACCUM) || (r_state == S_FLUSH)))
        r_acc <= r_acc + w_mult_ext;
      if ((r_state == S_OUT) && w_d_hs)
        r_cnt <= '0;
      else if (w_pair_hs && (r_state == S_ACCUM))
        r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign w_sel = (r_state == S_OUT) ? r_acc : w_mult_ext;

`ifdef MAC_MDC_SAT_EN
  logic signed [ACC_W-1:0]  w_shifted;
  logic [ACC_W-DATA_W:0]    w_upper;
  logic                     w_clamp_hi, w_clamp_lo, r_flag_sat;

  // bits above the result sign must all match the sign, otherwise the value is out of range
  assign w_shifted  = w_sel >>> r_cfg_shift;
  assign w_upper    = w_shifted[ACC_W-1:DATA_W-1];
  assign w_clamp_hi = !w_upper[ACC_W-DATA_W] && (|w_upper);
  assign w_clamp_lo = w_upper[ACC_W-DATA_W] && !(&w_upper);
  assign w_res      = w_clamp_hi ? {1'b0, {(DATA_W-1){1'b1}}} :
                      w_clamp_lo ? {1'b1, {(DATA_W-1){1'b0}}} :
                                   w_shifted[DATA_W-1:0];
  assign flag_sat   = r_flag_sat;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)                              r_flag_sat <= 1'b0;
    else if (d_TVALID && (w_clamp_hi || w_clamp_lo)) r_flag_sat <= 1'b1;
  end
`else
  assign w_res = DATA_W'(w_sel >>> r_cfg_shift);
`endif

  assign d_TDATA = d_TVALID ? w_res : '0;

endmodule
